// File: rtl/button_pkg.sv
// Shared constants and helpers for the push-button front end.
package button_pkg;

    localparam logic MODE_TOGGLE    = 1'b0;
    localparam logic MODE_MOMENTARY = 1'b1;

    function automatic int cnt_width(int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: two-flop synchronizer, stability counter, debounced level
// and a registered pulse on each accepted rising edge.
module debounce_ch
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic stable_next,
    output logic stable,
    output logic rise
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any edge where the synchronized input agrees with the accepted level restarts the count.
    always_comb begin
        sync1_d  = din;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        rise_d = stable_d & ~stable_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_next = stable_d;
    assign stable      = stable_q;
    assign rise        = rise_q;

endmodule

// File: rtl/button_toggle_bank.sv
// Multi-channel push-button bank: debounced buttons drive lights that either
// toggle per press or follow the debounced level.
module button_toggle_bank
    import button_pkg::*;
#(
    parameter int              N_CH            = 4,
    parameter int              DEBOUNCE_CYCLES = 1000000,
    parameter logic [N_CH-1:0] INIT_LIGHT      = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] button,
    input  logic [N_CH-1:0] mode,
    input  logic            clear,
    output logic [N_CH-1:0] light,
    output logic [N_CH-1:0] press_pulse
);

    logic [N_CH-1:0] stable_next;
    logic [N_CH-1:0] stable;
    logic [N_CH-1:0] light_q, light_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk        (clk),
            .rst        (rst),
            .din        (button[i]),
            .stable_next(stable_next[i]),
            .stable     (stable[i]),
            .rise       (press_pulse[i])
        );
    end

    // Toggle uses the same-edge rise so the light flips together with press_pulse.
    always_comb begin
        light_d = light_q;
        for (int i = 0; i < N_CH; i++) begin
            if (mode[i] == MODE_MOMENTARY) begin
                light_d[i] = stable_next[i];
            end else if (clear) begin
                light_d[i] = 1'b0;
            end else if (stable_next[i] & ~stable[i]) begin
                light_d[i] = ~light_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            light_q <= INIT_LIGHT;
        end else begin
            light_q <= light_d;
        end
    end

    assign light = light_q;

endmodule

// File: tb/tb_button_toggle_bank.sv
// Directed scoreboard bench: expectations are queued with the clock edge at
// which they must hold and are compared on the following falling edge.
module tb_button_toggle_bank;

    typedef struct {
        int         cycle;
        logic [3:0] light;
        logic [3:0] pulse;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] button;
    logic [3:0] mode;
    logic       clear;
    logic [3:0] light;
    logic [3:0] press_pulse;

    int   edge_cnt = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t sb[$];

    button_toggle_bank #(
        .N_CH           (4),
        .DEBOUNCE_CYCLES(4),
        .INIT_LIGHT     (4'b0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .button     (button),
        .mode       (mode),
        .clear      (clear),
        .light      (light),
        .press_pulse(press_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic applyStimulus(input logic r, input logic [3:0] b, input logic [3:0] m,
                                 input logic c);
        rst    = r;
        button = b;
        mode   = m;
        clear  = c;
    endtask

    task automatic push_expect(input int cyc, input logic [3:0] l, input logic [3:0] p,
                               input string tag);
        exp_t e;
        e.cycle = cyc;
        e.light = l;
        e.pulse = p;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input exp_t e);
        if (e.cycle != edge_cnt) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s missed: observed edge %0d expected edge %0d",
                     e.tag, edge_cnt, e.cycle);
        end else begin
            compared++;
            assert (light === e.light) else begin
                mismatched++;
                $error("[TB] FAIL %s light @%0d: observed %b expected %b",
                       e.tag, e.cycle, light, e.light);
            end
            compared++;
            assert (press_pulse === e.pulse) else begin
                mismatched++;
                $error("[TB] FAIL %s pulse @%0d: observed %b expected %b",
                       e.tag, e.cycle, press_pulse, e.pulse);
            end
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cycle <= edge_cnt) begin
            checkOutput(sb.pop_front());
        end
    end

    initial begin
        // Buttons held through reset are accepted six edges after release.
        applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b0);
        push_expect(1, 4'b0000, 4'b0000, "reset1");
        push_expect(2, 4'b0000, 4'b0000, "reset2");
        step(2);
        applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b0);
        for (int e = 3; e <= 7; e++) push_expect(e, 4'b0000, 4'b0000, "held_wait");
        push_expect(8, 4'b1111, 4'b1111, "held_accept");
        push_expect(9, 4'b1111, 4'b0000, "held_after");
        step(7);

        // Release all: falling edge gives no pulse and lights hold.
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
        push_expect(15, 4'b1111, 4'b0000, "release_all");
        step(8);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1);
        push_expect(18, 4'b0000, 4'b0000, "clear_all");
        step(1);

        // Clean press, release, second press on ch0.
        applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b0);
        push_expect(23, 4'b0000, 4'b0000, "ch0_pre");
        push_expect(24, 4'b0001, 4'b0001, "ch0_press1");
        push_expect(25, 4'b0001, 4'b0000, "ch0_post1");
        step(20);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
        push_expect(44, 4'b0001, 4'b0000, "ch0_release");
        push_expect(45, 4'b0001, 4'b0000, "ch0_release_hold");
        step(8);
        applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b0);
        push_expect(51, 4'b0001, 4'b0000, "ch0_pre2");
        push_expect(52, 4'b0000, 4'b0001, "ch0_press2");
        push_expect(53, 4'b0000, 4'b0000, "ch0_post2");
        step(8);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
        step(8);

        // Bounce on ch1: 1,0,1,1,0 then steady 1.
        for (int e = 63; e <= 72; e++) push_expect(e, 4'b0000, 4'b0000, "ch1_bounce");
        push_expect(73, 4'b0010, 4'b0010, "ch1_accept");
        push_expect(74, 4'b0010, 4'b0000, "ch1_post");
        applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b0);
        step(1);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1);
        applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b0);
        step(2);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1);
        applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b0);
        step(9);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
        step(8);

        // Momentary mode on ch2.
        applyStimulus(1'b0, 4'b0100, 4'b0100, 1'b0);
        push_expect(89, 4'b0010, 4'b0000, "ch2_mom_pre");
        push_expect(90, 4'b0110, 4'b0100, "ch2_mom_rise");
        push_expect(91, 4'b0110, 4'b0000, "ch2_mom_hold");
        push_expect(99, 4'b0110, 4'b0000, "ch2_mom_prefall");
        push_expect(100, 4'b0010, 4'b0000, "ch2_mom_fall");
        step(10);
        applyStimulus(1'b0, 4'b0000, 4'b0100, 1'b0);
        step(8);

        // Clear coinciding with an accepted ch3 press.
        applyStimulus(1'b0, 4'b0101, 4'b0100, 1'b0);
        push_expect(108, 4'b0111, 4'b0101, "setup_ch0_ch2");
        step(6);
        applyStimulus(1'b0, 4'b1101, 4'b0100, 1'b0);
        push_expect(113, 4'b0111, 4'b0000, "clear_pre");
        push_expect(114, 4'b0100, 4'b1000, "clear_priority");
        push_expect(115, 4'b0100, 4'b0000, "clear_post");
        step(5);
        applyStimulus(1'b0, 4'b1101, 4'b0100, 1'b1);
        step(1);
        applyStimulus(1'b0, 4'b0000, 4'b0100, 1'b0);
        step(8);

        // Reset in the middle of a ch3 debounce.
        applyStimulus(1'b0, 4'b1000, 4'b0000, 1'b0);
        for (int e = 123; e <= 132; e++) push_expect(e, 4'b0000, 4'b0000, "ch3_midrst");
        push_expect(133, 4'b1000, 4'b1000, "ch3_after_rst");
        push_expect(134, 4'b1000, 4'b0000, "ch3_post");
        step(4);
        applyStimulus(1'b1, 4'b1000, 4'b0000, 1'b0);
        step(1);
        applyStimulus(1'b0, 4'b1000, 4'b0000, 1'b0);
        step(12);

        if (sb.size() != 0) begin
            compared   += sb.size();
            mismatched += sb.size();
            $display("[TB] FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/button_toggle_bank.md
Name: button_toggle_bank

Overview:
Parametrised multi-channel push-button front end that succeeds the single-bit edge-toggled light.
- Each channel passes its raw asynchronous button through a synchronizer and a debouncer, then drives a light output.
- The light output either toggles on each debounced press (toggle mode) or follows the debounced button level (momentary mode).
- The block sits directly behind board button pins and drives LEDs or downstream control enables in the same clock domain.

Parameters:
- N_CH, 4: number of independent button/light channels (>=1).
- DEBOUNCE_CYCLES, 1000000: consecutive stable clk cycles required to accept a new button level (>=1).
- INIT_LIGHT, 0 (N_CH bits): light value loaded on reset, per channel.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- button  input  N_CH  raw asynchronous buttons; 1 = pressed.
- mode  input  N_CH  per-channel mode, registered use; 0 = toggle, 1 = momentary.
- clear  input  1  synchronous clear of all toggle-mode lights to 0.
- light  output  N_CH  registered light/state outputs.
- press_pulse  output  N_CH  registered one-cycle pulse per accepted debounced rising edge.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the clk rising edge.
- Reset values:
  - synchronizer flops, debounced level (stable) and counters: 0.
  - light = INIT_LIGHT.
  - press_pulse = 0.
  - Reset has priority over every other input.
- Synchronizer: 2 flops per channel. sync changes at edge k+2 for a button change set up before edge k.
- Debounce, per channel:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - On each edge where sync == stable, the counter is cleared to 0.
  - On each edge where sync != stable and counter < DEBOUNCE_CYCLES-1, the counter increments.
  - On each edge where sync != stable and counter == DEBOUNCE_CYCLES-1, stable <= sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES sync cycles never changes stable, and the counter restarts after any bounce.
- Latency: button change to stable update is DEBOUNCE_CYCLES+2 edges. light and press_pulse update on that same edge.
- press_pulse[i] = 1 for exactly one cycle on the edge where stable[i] goes 0->1. Falling transitions produce no pulse.
- Toggle mode (mode[i]=0): light[i] inverts on the edge where press_pulse[i] is asserted. Otherwise it holds.
- Momentary mode (mode[i]=1): light[i] <= stable_next[i] every edge, so it equals the debounced level with the same latency.
- clear:
  - On an edge with clear=1, every toggle-mode light goes to 0, overriding a simultaneous toggle.
  - Momentary-mode lights ignore clear.
  - press_pulse is unaffected by clear.
- Mode change:
  - momentary->toggle: light holds its current value.
  - toggle->momentary: light takes stable on the next edge.
- Button held through reset: after rst deasserts, stable=0. The held button is therefore accepted as a new press DEBOUNCE_CYCLES+2 edges later (pulse, plus toggle in toggle mode).
- Reset mid-debounce discards the partial count.
- Channels are fully independent. Simultaneous presses on several channels all pulse in the same cycle.

Decomposition:
- Shared package button_pkg:
  - MODE_TOGGLE = 1'b0 and MODE_MOMENTARY = 1'b1 constants.
  - function cnt_width(int cycles) returning $clog2(cycles+1).
- Sub-module debounce_ch, instantiated N_CH times by generate loop:
  - contains the synchronizer, counter, stable register and rise-pulse logic.
  - ports: clk, rst, din, stable_next, stable, rise.
- The top level holds the light registers, mode/clear muxing and the INIT_LIGHT reset.

Test Plan (N_CH=4, DEBOUNCE_CYCLES=4, INIT_LIGHT=4'b0000, mode=0 unless stated):
- Reset: assert rst 2 cycles while button=4'b1111 -> light=0, press_pulse=0. After release, press_pulse=4'b1111 for one cycle exactly 6 edges later, and light=4'b1111.
- Clean press on ch0: button[0] 0->1 held 20 cycles -> press_pulse[0] high 1 cycle at edge k+6, light[0] 0->1. Release -> no pulse, light[0] stays 1. Second press -> light[0] 1->0.
- Bounce rejection: button[1] pattern 1,0,1,1,0 (single cycles) then steady 1 -> no pulse during the bounce. Exactly one pulse 6 edges after the final steady 1 begins.
- Momentary mode: mode=4'b0100, button[2] high 10 cycles -> light[2] rises at k+6 and falls 6 edges after release. press_pulse[2] pulses once.
- clear priority: ch0 in toggle with light[0]=1, ch2 in momentary with light[2]=1; ch3 press accepted on the same edge as clear=1 -> light[0]=0, light[3]=0, light[2]=1, press_pulse[3]=1.
- Reset mid-debounce: button[3] high, assert rst at edge k+4 for 1 cycle, keep button high -> no pulse before reset. Pulse occurs 6 edges after rst release.
